lcd_bus_decoder: RTL and testbench

- Receiving end of the HD44780-style character-LCD write bus (RS/RW/EN/DATA[7:0]) that our LCD drivers generate.
- Snoops the bus and decodes instructions and data writes.
- Keeps a DDRAM image of both display lines and exposes it through a registered read port.
- Serves as an on-chip display mirror for status/debug logic and as a checker for LCD driver blocks.

---
 rtl/lcd_bus_decoder.sv | 137 +++++++++++++
 tb/tb_lcd_bus_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: HD44780 write-bus snooper with a DDRAM image mirror (optional stats via LCD_BUS_DECODER_STATS_EN)
module lcd_bus_decoder #(
  parameter int LINE_LEN = 16,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       func_8bit,
  output logic       busy,
  output logic       data_wr,
  output logic       frame_done,
  output logic       addr_err,
  output logic       overrun
`ifdef LCD_BUS_DECODER_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);
  localparam int N = 2 * LINE_LEN;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0] L7 = 7'(LINE_LEN);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [7:0] img [N];
  logic [10:0] s1, s2;
  logic en_d, id, cgram;
  logic [AW-1:0] clr_idx, wi, ra;
  logic rs, rw, fall, in1, in2;
  logic [7:0] dat;
  assign {rs, rw} = s2[10:9];
  assign dat = s2[7:0];
  assign fall = en_d & ~s2[8];
  assign in1 = cur_addr < L7;
  assign in2 = cur_addr >= 7'h40 && cur_addr < 7'h40 + L7;
  assign wi = in1 ? AW'(cur_addr) : AW'(cur_addr - 7'h40 + L7);
  assign ra = AW'(rd_addr);
  function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
    return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
               : (a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1);
  endfunction
  // two-flop bus synchronizer plus a delayed EN for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= '0;
      s2 <= '0;
      en_d <= 1'b0;
    end else begin
      s1 <= {LCD_RS, LCD_RW, LCD_EN, LCD_DATA};
      s2 <= s1;
      en_d <= s2[8];
    end
  end
  // decoder FSM: instruction/data decode in IDLE, one blanked cell per cycle in CLEAR
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) img[i] <= BLANK_CHAR;
      state <= IDLE;
      cur_addr <= '0;
      id <= 1'b1;
      cgram <= 1'b0;
      disp_on <= 1'b0;
      func_8bit <= 1'b0;
      busy <= 1'b0;
      clr_idx <= '0;
      data_wr <= 1'b0;
      frame_done <= 1'b0;
      addr_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      data_wr <= 1'b0;
      frame_done <= 1'b0;
      addr_err <= 1'b0;
      overrun <= 1'b0;
      if (state == CLEAR) begin
        img[clr_idx] <= BLANK_CHAR;
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == AW'(N - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        if (fall && !rw) overrun <= 1'b1;
      end else if (fall && !rw) begin
        if (rs) begin
          if (!cgram) begin
            data_wr <= 1'b1;
            if (in1 || in2) img[wi] <= dat;
            else addr_err <= 1'b1;
            if (cur_addr == 7'h40 + L7 - 7'd1) frame_done <= 1'b1;
            cur_addr <= step(cur_addr, id);
          end
        end else if (dat[7]) begin
          cur_addr <= dat[6:0];
          cgram <= 1'b0;
        end else if (dat[6]) cgram <= 1'b1;
        else if (dat[5]) func_8bit <= dat[4];
        else if (dat[4]) begin
          if (!dat[3]) cur_addr <= step(cur_addr, dat[2]);
        end else if (dat[3]) disp_on <= dat[2];
        else if (dat[2]) id <= dat[1];
        else if (dat[1]) cur_addr <= '0;
        else if (dat[0]) begin
          cur_addr <= '0;
          id <= 1'b1;
          state <= CLEAR;
          busy <= 1'b1;
          clr_idx <= '0;
        end
      end
    end
  end
  // registered image read port; indices past the image read as blank
  always_ff @(posedge CLK) begin
    if (RESET) rd_data <= BLANK_CHAR;
    else rd_data <= ({27'd0, rd_addr} < 32'(N)) ? img[ra] : BLANK_CHAR;
  end
`ifdef LCD_BUS_DECODER_STATS_EN
  // saturating write and error counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_count <= '0;
      err_count <= '0;
    end else begin
      if (data_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if ((addr_err || overrun) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed self-checking bench for lcd_bus_decoder
module tb_lcd_bus_decoder;
  logic CLK = 0, RESET = 1, LCD_RS = 0, LCD_RW = 0, LCD_EN = 0;
  logic [7:0] LCD_DATA = 0;
  logic [4:0] rd_addr = 0;
  logic [7:0] rd_data;
  logic [6:0] cur_addr;
  logic disp_on, func_8bit, busy, data_wr, frame_done, addr_err, overrun;
  int n_chk = 0, n_fail = 0;
  int n_wr = 0, n_fd = 0, fd_at = 0, n_aerr = 0, n_ovr = 0, n_busy = 0;
  logic [7:0] v;
  int bad;
`ifdef LCD_BUS_DECODER_STATS_EN
  logic [15:0] wr_count, err_count;
`endif
  lcd_bus_decoder dut (
    .CLK(CLK), .RESET(RESET), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_DATA(LCD_DATA), .rd_addr(rd_addr), .rd_data(rd_data), .cur_addr(cur_addr),
    .disp_on(disp_on), .func_8bit(func_8bit), .busy(busy), .data_wr(data_wr),
    .frame_done(frame_done), .addr_err(addr_err), .overrun(overrun)
`ifdef LCD_BUS_DECODER_STATS_EN
    , .wr_count(wr_count), .err_count(err_count)
`endif
  );
  always #5 CLK = ~CLK;
  // pulse and busy-cycle counters sampled away from the active edge
  always @(negedge CLK) begin
    if (data_wr) n_wr <= n_wr + 1;
    if (frame_done) begin
      n_fd <= n_fd + 1;
      fd_at <= n_wr + 1;
    end
    if (addr_err) n_aerr <= n_aerr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (busy) n_busy <= n_busy + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge CLK);
    LCD_RS = rs;
    LCD_RW = rw;
    LCD_DATA = d;
    LCD_EN = 1;
    repeat (3) @(negedge CLK);
    LCD_EN = 0;
  endtask
  task automatic bus(input logic rs, input logic rw, input logic [7:0] d);
    strobe(rs, rw, d);
    repeat (6) @(negedge CLK);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) bus(1, 0, s[i]);
  endtask
  task automatic rd(input int a, output logic [7:0] q);
    @(negedge CLK);
    rd_addr = a[4:0];
    @(negedge CLK);
    q = rd_data;
  endtask
  task automatic chk_str(input int base, input string s);
    logic [7:0] q;
    for (int i = 0; i < s.len(); i++) begin
      rd(base + i, q);
      check($sformatf("img%0d", base + i), q, s[i]);
    end
  endtask
  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (busy !== lvl && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, busy, lvl);
  endtask
  task automatic count_blank(output int nb);
    logic [7:0] q;
    nb = 0;
    for (int i = 0; i < 32; i++) begin
      rd(i, q);
      if (q !== 8'h20) nb++;
    end
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    RESET = 0;
    check("rst_rd", rd_data, 8'h20);
    check("rst_ac", cur_addr, 7'h00);
    check("rst_flags", {disp_on, func_8bit, busy}, 3'b000);
    check("rst_pulses", {data_wr, frame_done, addr_err, overrun}, 4'b0000);
    // init sequence and line 1
    bus(0, 0, 8'h38);
    bus(0, 0, 8'h38);
    bus(0, 0, 8'h0E);
    bus(0, 0, 8'h06);
    bus(0, 0, 8'h02);
    bus(0, 0, 8'h01);
    wait_busy(0, "init_clr_done");
    bus(0, 0, 8'h80);
    send_str("ENTER PASSWORD  ");
    chk_str(0, "ENTER PASSWORD  ");
    check("disp_on", disp_on, 1);
    check("func_8bit", func_8bit, 1);
    check("ac_l1", cur_addr, 7'h10);
    check("wr_l1", n_wr, 16);
    check("fd_l1", n_fd, 0);
    // line 2 and frame_done
    bus(0, 0, 8'hC0);
    send_str("KEY VALUE : 7   ");
    chk_str(16, "KEY VALUE : 7   ");
    check("fd_cnt", n_fd, 1);
    check("fd_at", fd_at, 32);
    check("ac_l2", cur_addr, 7'h50);
    // out-of-window write and 0x27 -> 0x40 wrap
    bus(0, 0, 8'hA7);
    bus(1, 0, "A");
    check("aerr", n_aerr, 1);
    check("ac_wrap", cur_addr, 7'h40);
    bus(1, 0, "B");
    rd(16, v);
    check("img16_B", v, "B");
    check("ac_41", cur_addr, 7'h41);
    check("aerr_once", n_aerr, 1);
    check("wr_34", n_wr, 34);
    // decrement mode, 0x00 -> 0x67 and shift-right 0x67 -> 0x00
    bus(0, 0, 8'h04);
    bus(0, 0, 8'h80);
    bus(1, 0, "X");
    rd(0, v);
    check("img0_X", v, "X");
    check("ac_dec_wrap", cur_addr, 7'h67);
    bus(0, 0, 8'h14);
    check("ac_shift_wrap", cur_addr, 7'h00);
    // fill, clear with overrun attempt
    bus(0, 0, 8'h06);
    bus(0, 0, 8'h80);
    send_str("abcdefghijklmnop");
    bus(0, 0, 8'hC0);
    send_str("qrstuvwxyz012345");
    rd(31, v);
    check("fill31", v, "5");
    n_busy = 0;
    strobe(0, 0, 8'h01);
    wait_busy(1, "clr_rise");
    repeat (5) @(negedge CLK);
    bus(1, 0, "Z");
    wait_busy(0, "clr_fall");
    check("busy_cycles", n_busy, 32);
    check("ovr", n_ovr, 1);
    check("wr_ovr_drop", n_wr, 67);
    check("ac_clr", cur_addr, 7'h00);
    count_blank(bad);
    check("clr_blank", bad, 0);
    // reset aborting a clear, then an ignored read transaction
    bus(0, 0, 8'hCF);
    bus(1, 0, "Q");
    bus(0, 0, 8'h0C);
    strobe(0, 0, 8'h01);
    wait_busy(1, "clr2_rise");
    repeat (5) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    check("rst_busy", busy, 0);
    check("rst_ac2", cur_addr, 7'h00);
    check("rst_disp", disp_on, 0);
    strobe(0, 1, 8'h8C);
    repeat (6) @(negedge CLK);
    check("rw_ac", cur_addr, 7'h00);
    check("rw_wr", n_wr, 68);
    check("rw_ovr", n_ovr, 1);
    check("rw_busy", busy, 0);
    count_blank(bad);
    check("rst_blank", bad, 0);
`ifdef LCD_BUS_DECODER_STATS_EN
    check("wr_count", wr_count, 16'd0);
    bus(1, 0, "R");
    check("wr_count1", wr_count, 16'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
